// File: rtl/fc_layer_stream.sv
`default_nettype none
// ============================================================================
// fc_layer_stream : streamed fully-connected layer, LANES neurons per pass
// Revision 1.0 - initial release
// ============================================================================
module fc_layer_stream #(
    parameter int IN_DIM    = 784,
    parameter int OUT_DIM   = 10,
    parameter int LANES     = 2,
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 24
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       relu_en,
    input  logic                       x_valid,
    input  logic [WIDTH-1:0]           x_data,
    output logic                       x_ready,
    input  logic                       w_valid,
    input  logic [LANES*WIDTH-1:0]     w_data,
    output logic                       w_ready,
    output logic                       y_valid,
    output logic [WIDTH-1:0]           y_data,
    output logic [$clog2(OUT_DIM)-1:0] y_index,
    input  logic                       y_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       sat_flag
);
    localparam int GROUPS = OUT_DIM / LANES;
    localparam int ACC_W  = 2*WIDTH + $clog2(IN_DIM) + 1;
    localparam int CNT_W  = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
    localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int IDX_W  = $clog2(OUT_DIM);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_X = 3'd1;
    localparam logic [2:0] S_BIAS   = 3'd2;
    localparam logic [2:0] S_MAC    = 3'd3;
    localparam logic [2:0] S_FINAL  = 3'd4;
    localparam logic [2:0] S_DRAIN  = 3'd5;

    localparam logic signed [ACC_W-1:0] HALF  = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_BITS-1);
    localparam logic signed [ACC_W-1:0] MAXV  = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV  = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]        MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]        MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2:0]              state;
    logic [CNT_W-1:0]        cnt;
    logic [GRP_W-1:0]        grp;
    logic [LANE_W-1:0]       lane;
    logic                    relu_q;
    logic signed [WIDTH-1:0] xbuf [IN_DIM];
    logic signed [ACC_W-1:0] acc  [LANES];
    logic [WIDTH-1:0]        res  [LANES];

    logic signed [WIDTH-1:0]   w_lane   [LANES];
    logic signed [2*WIDTH-1:0] prod     [LANES];
    logic signed [ACC_W-1:0]   prod_ext [LANES];
    logic signed [ACC_W-1:0]   bias_ext [LANES];
    logic signed [ACC_W-1:0]   rnd      [LANES];
    logic signed [ACC_W-1:0]   shf      [LANES];
    logic [WIDTH-1:0]          fin      [LANES];
    logic [LANES-1:0]          lane_sat;

    assign x_ready = (state == S_LOAD_X);
    assign w_ready = (state == S_BIAS) || (state == S_MAC);
    assign y_valid = (state == S_DRAIN);
    assign busy    = (state != S_IDLE);
    assign y_data  = y_valid ? res[lane] : '0;
    assign y_index = y_valid ? (IDX_W'(grp) * IDX_W'(LANES) + IDX_W'(lane)) : '0;

    // Round half-up, clip to the output range, then optional ReLU.
    always_comb begin
        lane_sat = '0;
        for (int k = 0; k < LANES; k++) begin
            w_lane[k]   = w_data[k*WIDTH +: WIDTH];
            prod[k]     = w_lane[k] * xbuf[cnt];
            prod_ext[k] = {{(ACC_W-2*WIDTH){prod[k][2*WIDTH-1]}}, prod[k]};
            bias_ext[k] = {{(ACC_W-WIDTH){w_lane[k][WIDTH-1]}}, w_lane[k]};
            rnd[k]      = acc[k] + HALF;
            shf[k]      = rnd[k] >>> FRAC_BITS;
            if (shf[k] > MAXV) begin
                fin[k]      = MAX_W;
                lane_sat[k] = 1'b1;
            end else if (shf[k] < MINV) begin
                fin[k]      = MIN_W;
                lane_sat[k] = 1'b1;
            end else begin
                fin[k] = shf[k][WIDTH-1:0];
            end
            if (relu_q && fin[k][WIDTH-1])
                fin[k] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (x_ready && x_valid)
            xbuf[cnt] <= x_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            grp      <= '0;
            lane     <= '0;
            relu_q   <= 1'b0;
            sat_flag <= 1'b0;
            done     <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                acc[k] <= '0;
                res[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LOAD_X;
                        sat_flag <= 1'b0;
                        relu_q   <= relu_en;
                        cnt      <= '0;
                        grp      <= '0;
                        lane     <= '0;
                    end
                end
                S_LOAD_X: begin
                    if (x_valid) begin
                        if (cnt == CNT_W'(IN_DIM-1)) begin
                            cnt   <= '0;
                            state <= S_BIAS;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_BIAS: begin
                    if (w_valid) begin
                        for (int k = 0; k < LANES; k++)
                            acc[k] <= bias_ext[k] <<< FRAC_BITS;
                        cnt   <= '0;
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (w_valid) begin
                        for (int k = 0; k < LANES; k++)
                            acc[k] <= acc[k] + prod_ext[k];
                        if (cnt == CNT_W'(IN_DIM-1)) begin
                            cnt   <= '0;
                            state <= S_FINAL;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_FINAL: begin
                    for (int k = 0; k < LANES; k++)
                        res[k] <= fin[k];
                    if (|lane_sat)
                        sat_flag <= 1'b1;
                    lane  <= '0;
                    state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (y_ready) begin
                        if (lane == LANE_W'(LANES-1)) begin
                            lane <= '0;
                            if (grp == GRP_W'(GROUPS-1)) begin
                                grp   <= '0;
                                done  <= 1'b1;
                                state <= S_IDLE;
                            end else begin
                                grp   <= grp + 1'b1;
                                state <= S_BIAS;
                            end
                        end else begin
                            lane <= lane + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fc_layer_stream.sv
`default_nettype none
// tb_fc_layer_stream : table-driven bench with a result scoreboard queue
// (IN_DIM=4, OUT_DIM=4, LANES=2, WIDTH=16, FRAC_BITS=8).
module tb_fc_layer_stream;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, relu_en = 1'b0;
    logic        x_valid = 1'b0, w_valid = 1'b0, y_ready = 1'b1;
    logic [15:0] x_data = '0;
    logic [31:0] w_data = '0;
    logic        x_ready, w_ready, y_valid, busy, done, sat_flag;
    logic [15:0] y_data;
    logic [1:0]  y_index;

    fc_layer_stream #(.IN_DIM(4), .OUT_DIM(4), .LANES(2), .WIDTH(16), .FRAC_BITS(8)) dut (
        .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
        .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .y_valid(y_valid), .y_data(y_data), .y_index(y_index), .y_ready(y_ready),
        .busy(busy), .done(done), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][15:0]       x;
        logic [1:0][1:0][15:0]  b;   // [group][lane]
        logic [1:0][3:0][1:0][15:0] w; // [group][beat][lane]
        bit                     relu;
        logic [3:0][15:0]       y;
        bit                     sat;
    } vec_t;

    vec_t        tbl [7];
    logic [17:0] exp_q [$];
    logic [17:0] e;
    int          n_pass = 0, n_total = 0;
    int          cyc = 0, t0 = 0;
    bit          stall_out = 1'b0, stall_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic vec_t mk_uni(logic [15:0] xv, logic [15:0] wv, logic [15:0] bv,
                                    bit r, logic [15:0] yv, bit s);
        vec_t v;
        for (int j = 0; j < 4; j++) v.x[j] = xv;
        for (int g = 0; g < 2; g++)
            for (int l = 0; l < 2; l++) begin
                v.b[g][l] = bv;
                for (int j = 0; j < 4; j++) v.w[g][j][l] = wv;
            end
        v.relu = r;
        for (int k = 0; k < 4; k++) v.y[k] = yv;
        v.sat = s;
        return v;
    endfunction

    // Reference arithmetic in 64-bit integers.
    function automatic logic [15:0] model_y(vec_t v, int g, int l, output bit s);
        longint acc;
        acc = longint'($signed(v.b[g][l])) * 256;
        for (int j = 0; j < 4; j++)
            acc += longint'($signed(v.x[j])) * longint'($signed(v.w[g][j][l]));
        acc = (acc + 128) >>> 8;
        s = 1'b0;
        if (acc > 32767) begin acc = 32767; s = 1'b1; end
        else if (acc < -32768) begin acc = -32768; s = 1'b1; end
        if (v.relu && acc < 0) acc = 0;
        return acc[15:0];
    endfunction

    always @(negedge clk) begin
        if (y_valid && y_ready) begin
            chk("w_ready_in_drain", {31'b0, w_ready}, 0);
            chk("x_ready_in_drain", {31'b0, x_ready}, 0);
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_y: got idx %0d data %0h expected no beat", y_index, y_data);
            end else begin
                e = exp_q.pop_front();
                chk("y_data", {16'b0, y_data}, {16'b0, e[15:0]});
                chk("y_index", {30'b0, y_index}, {30'b0, e[17:16]});
            end
        end
    end

    // Holds y_ready low for 5 cycles at the first result of a stalled run.
    initial begin : ready_ctrl
        logic [15:0] hd;
        logic [1:0]  hi;
        forever begin
            @(posedge clk); #1;
            if (stall_out && !stall_done && y_valid) begin
                y_ready = 1'b0;
                hd = y_data;
                hi = y_index;
                repeat (5) begin
                    @(negedge clk);
                    chk("hold_valid", {31'b0, y_valid}, 1);
                    chk("hold_data", {16'b0, y_data}, {16'b0, hd});
                    chk("hold_index", {30'b0, y_index}, {30'b0, hi});
                end
                @(posedge clk); #1;
                y_ready = 1'b1;
                stall_done = 1'b1;
            end
        end
    end

    task automatic start_run(input bit r);
        start = 1'b1;
        relu_en = r;
        @(posedge clk); #1;
        start = 1'b0;
        relu_en = 1'b0;
        t0 = cyc;
        chk("busy_after_start", {31'b0, busy}, 1);
        chk("sat_cleared", {31'b0, sat_flag}, 0);
    endtask

    task automatic push_x(input logic [15:0] d, input int gap);
        bit rdy;
        int n;
        repeat (gap) begin @(posedge clk); #1; end
        x_valid = 1'b1;
        x_data = d;
        n = 0;
        do begin @(negedge clk); rdy = x_ready; @(posedge clk); #1; n++; end
        while (!rdy && n < 300);
        if (!rdy) begin n_total++; $display("FAIL x_timeout: got no x_ready expected accept"); end
        x_valid = 1'b0;
    endtask

    task automatic push_w(input logic [31:0] d, input int gap);
        bit rdy;
        int n;
        repeat (gap) begin @(posedge clk); #1; end
        w_valid = 1'b1;
        w_data = d;
        n = 0;
        do begin @(negedge clk); rdy = w_ready; @(posedge clk); #1; n++; end
        while (!rdy && n < 300);
        if (!rdy) begin n_total++; $display("FAIL w_timeout: got no w_ready expected accept"); end
        w_valid = 1'b0;
    endtask

    task automatic wait_done(input bit sat, input bit lat);
        int n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 300);
        chk("done_seen", {31'b0, done}, 1);
        if (lat) chk("latency", cyc - t0, 20);
        chk("busy_at_done", {31'b0, busy}, 0);
        chk("sat_flag", {31'b0, sat_flag}, {31'b0, sat});
        chk("results_drained", exp_q.size(), 0);
        @(negedge clk);
        chk("done_one_cycle", {31'b0, done}, 0);
    endtask

    task automatic run_vec(input vec_t v, input bit gaps, input bit stall, input bit lat, input bit poke);
        for (int k = 0; k < 4; k++) exp_q.push_back({2'(k), v.y[k]});
        stall_out = stall;
        stall_done = 1'b0;
        start_run(v.relu);
        for (int j = 0; j < 4; j++) push_x(v.x[j], gaps ? int'($urandom_range(0, 3)) : 0);
        for (int g = 0; g < 2; g++) begin
            push_w(v.b[g], gaps ? int'($urandom_range(0, 3)) : 0);
            if (poke && g == 0) begin
                start = 1'b1;
                relu_en = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                relu_en = 1'b0;
                chk("start_ignored_xready", {31'b0, x_ready}, 0);
                chk("start_ignored_busy", {31'b0, busy}, 1);
            end
            for (int j = 0; j < 4; j++) push_w(v.w[g][j], gaps ? int'($urandom_range(0, 3)) : 0);
        end
        wait_done(v.sat, lat);
        stall_out = 1'b0;
    endtask

    initial begin
        vec_t rv;
        bit   s, sacc;

        tbl[0] = mk_uni(16'd256, 16'd128, 16'd64, 1'b0, 16'd576, 1'b0);
        tbl[1] = mk_uni(16'h7F00, 16'h7F00, 16'd0, 1'b0, 16'h7FFF, 1'b1);
        tbl[2] = mk_uni(16'h7F00, 16'h8100, 16'd0, 1'b0, 16'h8000, 1'b1);
        tbl[3] = mk_uni(16'd0, 16'd128, 16'd0, 1'b0, 16'd1, 1'b0);
        tbl[3].x[0] = 16'd1;
        tbl[4] = mk_uni(16'd0, 16'd0, 16'hFF00, 1'b0, 16'hFF00, 1'b0);
        tbl[5] = mk_uni(16'd0, 16'd0, 16'hFF00, 1'b1, 16'h0000, 1'b0);
        tbl[6] = mk_uni(16'd0, 16'd0, 16'd0, 1'b0, 16'd0, 1'b0);
        tbl[6].x[0] = 16'd256;   tbl[6].x[1] = 16'd512;
        tbl[6].x[2] = 16'hFF00;  tbl[6].x[3] = 16'd128;
        tbl[6].b[0][0] = 16'd1;  tbl[6].b[0][1] = 16'd0;
        tbl[6].b[1][0] = 16'd2;  tbl[6].b[1][1] = 16'hFFFD;
        tbl[6].w[0][0][0] = 16'd1; tbl[6].w[0][1][0] = 16'd2;
        tbl[6].w[0][2][0] = 16'd3; tbl[6].w[0][3][0] = 16'd4;
        tbl[6].w[0][0][1] = 16'hFFFF;
        tbl[6].w[1][3][0] = 16'd2;
        tbl[6].w[1][2][1] = 16'd1;
        tbl[6].y[0] = 16'd5;     tbl[6].y[1] = 16'hFFFF;
        tbl[6].y[2] = 16'd3;     tbl[6].y[3] = 16'hFFFC;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {x_ready, w_ready, y_valid, busy, done, sat_flag, y_index, y_data}, 0);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(tbl[i], 1'b0, 1'b0, 1'b1, 1'b0);

        run_vec(tbl[6], 1'b1, 1'b1, 1'b0, 1'b0);

        for (int j = 0; j < 4; j++) rv.x[j] = 16'($urandom_range(0, 2047)) - 16'd1024;
        for (int g = 0; g < 2; g++)
            for (int l = 0; l < 2; l++) begin
                rv.b[g][l] = 16'($urandom_range(0, 511)) - 16'd256;
                for (int j = 0; j < 4; j++) rv.w[g][j][l] = 16'($urandom);
            end
        rv.relu = 1'($urandom_range(0, 1));
        sacc = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rv.y[k] = model_y(rv, k / 2, k % 2, s);
            sacc |= s;
        end
        rv.sat = sacc;
        run_vec(rv, 1'b1, 1'b1, 1'b0, 1'b0);

        run_vec(tbl[4], 1'b0, 1'b0, 1'b0, 1'b1);

        // Abort a saturating run in the MAC phase of group 1.
        exp_q.push_back({2'd0, 16'h7FFF});
        exp_q.push_back({2'd1, 16'h7FFF});
        start_run(1'b0);
        for (int j = 0; j < 4; j++) push_x(tbl[1].x[j], 0);
        push_w(tbl[1].b[0], 0);
        for (int j = 0; j < 4; j++) push_w(tbl[1].w[0][j], 0);
        push_w(tbl[1].b[1], 0);
        push_w(tbl[1].w[1][0], 0);
        push_w(tbl[1].w[1][1], 0);
        chk("sat_before_reset", {31'b0, sat_flag}, 1);
        chk("busy_before_reset", {31'b0, busy}, 1);
        #3 reset = 1'b0;
        #1;
        chk("midrun_reset_outputs", {x_ready, w_ready, y_valid, busy, done, sat_flag, y_index, y_data}, 0);
        chk("group0_drained", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        run_vec(tbl[0], 1'b0, 1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
